// File: rtl/alu_operand_stage_if.sv
// Decode-to-execute operand bus: ID fields, forwarding sources, flush and the
// execute-slot outputs of alu_operand_stage.
interface alu_operand_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            id_valid;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [XLEN-1:0] id_pc;
    logic [3:0]      id_alu_sel;
    logic            id_alu_src_imm;
    logic            id_alu_src_pc;
    logic            id_reg_write;
    logic            id_mem_read;
    logic            id_mem_write;

    logic            exmem_reg_write;
    logic [4:0]      exmem_rd;
    logic [XLEN-1:0] exmem_result;
    logic            memwb_reg_write;
    logic [4:0]      memwb_rd;
    logic [XLEN-1:0] memwb_result;
    logic            flush;

    logic            ex_valid;
    logic [XLEN-1:0] ex_src1;
    logic [XLEN-1:0] ex_src2;
    logic [XLEN-1:0] ex_store_data;
    logic [3:0]      ex_alu_sel;
    logic [4:0]      ex_rd;
    logic [XLEN-1:0] ex_pc;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic            stall;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
               id_imm, id_pc, id_alu_sel, id_alu_src_imm, id_alu_src_pc,
               id_reg_write, id_mem_read, id_mem_write,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result, flush,
        input  ex_valid, ex_src1, ex_src2, ex_store_data, ex_alu_sel, ex_rd,
               ex_pc, ex_reg_write, ex_mem_read, ex_mem_write, stall
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
               id_imm, id_pc, id_alu_sel, id_alu_src_imm, id_alu_src_pc,
               id_reg_write, id_mem_read, id_mem_write,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result, flush,
        output ex_valid, ex_src1, ex_src2, ex_store_data, ex_alu_sel, ex_rd,
               ex_pc, ex_reg_write, ex_mem_read, ex_mem_write, stall
    );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with load-use stall detection, writeback bypass on
// capture and EX/MEM / MEM/WB operand forwarding.
module alu_operand_stage #(
    parameter int unsigned XLEN = 32
) (
    input logic               clk,
    input logic               rst,
    alu_operand_stage_if.slave bus
);
    localparam logic [3:0] ALU_NOP = 4'hF;

    logic            s_valid;
    logic [4:0]      s_rs1;
    logic [4:0]      s_rs2;
    logic [4:0]      s_rd;
    logic [XLEN-1:0] s_rs1_data;
    logic [XLEN-1:0] s_rs2_data;
    logic [XLEN-1:0] s_imm;
    logic [XLEN-1:0] s_pc;
    logic [3:0]      s_alu_sel;
    logic            s_src_imm;
    logic            s_src_pc;
    logic            s_reg_write;
    logic            s_mem_read;
    logic            s_mem_write;

    logic            stall;
    logic            byp1;
    logic            byp2;
    logic [XLEN-1:0] fwd1;
    logic [XLEN-1:0] fwd2;

    always_comb begin
        stall = 1'b0;
        if (bus.id_valid && s_valid && s_mem_read && (s_rd != 5'd0) &&
            ((s_rd == bus.id_rs1) || (s_rd == bus.id_rs2)) && !bus.flush)
            stall = 1'b1;
    end

    // Register file writes at the same edge we capture, so catch that value here.
    always_comb begin
        byp1 = bus.memwb_reg_write && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == bus.id_rs1);
        byp2 = bus.memwb_reg_write && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == bus.id_rs2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_valid     <= 1'b0;
            s_rs1       <= '0;
            s_rs2       <= '0;
            s_rd        <= '0;
            s_rs1_data  <= '0;
            s_rs2_data  <= '0;
            s_imm       <= '0;
            s_pc        <= '0;
            s_alu_sel   <= ALU_NOP;
            s_src_imm   <= 1'b0;
            s_src_pc    <= 1'b0;
            s_reg_write <= 1'b0;
            s_mem_read  <= 1'b0;
            s_mem_write <= 1'b0;
        end else if (bus.flush || stall) begin
            s_valid     <= 1'b0;
            s_alu_sel   <= ALU_NOP;
            s_reg_write <= 1'b0;
            s_mem_read  <= 1'b0;
            s_mem_write <= 1'b0;
        end else begin
            s_valid     <= bus.id_valid;
            s_rs1       <= bus.id_rs1;
            s_rs2       <= bus.id_rs2;
            s_rd        <= bus.id_rd;
            s_rs1_data  <= byp1 ? bus.memwb_result : bus.id_rs1_data;
            s_rs2_data  <= byp2 ? bus.memwb_result : bus.id_rs2_data;
            s_imm       <= bus.id_imm;
            s_pc        <= bus.id_pc;
            s_alu_sel   <= bus.id_valid ? bus.id_alu_sel : ALU_NOP;
            s_src_imm   <= bus.id_alu_src_imm;
            s_src_pc    <= bus.id_alu_src_pc;
            s_reg_write <= bus.id_valid && bus.id_reg_write;
            s_mem_read  <= bus.id_valid && bus.id_mem_read;
            s_mem_write <= bus.id_valid && bus.id_mem_write;
        end
    end

    // EX/MEM is younger than MEM/WB, so it is checked first.
    always_comb begin
        fwd1 = s_rs1_data;
        if (bus.exmem_reg_write && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == s_rs1))
            fwd1 = bus.exmem_result;
        else if (bus.memwb_reg_write && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == s_rs1))
            fwd1 = bus.memwb_result;

        fwd2 = s_rs2_data;
        if (bus.exmem_reg_write && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == s_rs2))
            fwd2 = bus.exmem_result;
        else if (bus.memwb_reg_write && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == s_rs2))
            fwd2 = bus.memwb_result;
    end

    always_comb begin
        bus.stall         = stall;
        bus.ex_valid      = s_valid;
        bus.ex_src1       = s_src_pc  ? s_pc  : fwd1;
        bus.ex_src2       = s_src_imm ? s_imm : fwd2;
        bus.ex_store_data = fwd2;
        bus.ex_alu_sel    = s_alu_sel;
        bus.ex_rd         = s_rd;
        bus.ex_pc         = s_pc;
        bus.ex_reg_write  = s_reg_write;
        bus.ex_mem_read   = s_mem_read;
        bus.ex_mem_write  = s_mem_write;
    end
endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed hazard scenarios followed by
// randomized traffic, checked against an instruction-level reference model.
module tb_alu_operand_stage;
    localparam logic [3:0] ALU_NOP = 4'hF;

    typedef struct {
        logic        valid;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm, pc;
        logic [3:0]  alu;
        logic        src_imm, src_pc, rw, mr, mw;
    } instr_t;

    typedef struct {
        logic        valid, stall, rw, mr, mw;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic [31:0] src1, src2, sd, pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   failed = 0;
    exp_t sb[$];
    instr_t ex_slot;

    alu_operand_stage_if #(.XLEN(32)) bus ();

    alu_operand_stage #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic instr_t bubble();
        instr_t b;
        b = '{valid: 1'b0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, d1: 32'd0, d2: 32'd0,
              imm: 32'd0, pc: 32'd0, alu: ALU_NOP, src_imm: 1'b0, src_pc: 1'b0,
              rw: 1'b0, mr: 1'b0, mw: 1'b0};
        return b;
    endfunction

    // Value an instruction in EX actually sees for register r, given its stale copy.
    function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] stale);
        if (r == 0) return stale;
        if (bus.exmem_reg_write && bus.exmem_rd == r) return bus.exmem_result;
        if (bus.memwb_reg_write && bus.memwb_rd == r) return bus.memwb_result;
        return stale;
    endfunction

    function automatic logic [31:0] wb_read(input logic [4:0] r, input logic [31:0] rf);
        if (r != 0 && bus.memwb_reg_write && bus.memwb_rd == r) return bus.memwb_result;
        return rf;
    endfunction

    // Predict this cycle's outputs, queue them, then advance the model by one edge.
    task automatic issue();
        exp_t   e;
        instr_t n;
        logic   load_use;
        #1;
        load_use = bus.id_valid && ex_slot.valid && ex_slot.mr && ex_slot.rd != 0 &&
                   (ex_slot.rd == bus.id_rs1 || ex_slot.rd == bus.id_rs2) && !bus.flush;
        e.valid = ex_slot.valid;
        e.stall = load_use;
        e.rw    = ex_slot.rw;
        e.mr    = ex_slot.mr;
        e.mw    = ex_slot.mw;
        e.alu   = ex_slot.alu;
        e.rd    = ex_slot.rd;
        e.pc    = ex_slot.pc;
        e.src1  = ex_slot.src_pc  ? ex_slot.pc  : operand(ex_slot.rs1, ex_slot.d1);
        e.sd    = operand(ex_slot.rs2, ex_slot.d2);
        e.src2  = ex_slot.src_imm ? ex_slot.imm : e.sd;
        sb.push_back(e);

        if (bus.flush || load_use || !bus.id_valid) begin
            ex_slot = bubble();
        end else begin
            n.valid   = 1'b1;
            n.rs1     = bus.id_rs1;
            n.rs2     = bus.id_rs2;
            n.rd      = bus.id_rd;
            n.d1      = wb_read(bus.id_rs1, bus.id_rs1_data);
            n.d2      = wb_read(bus.id_rs2, bus.id_rs2_data);
            n.imm     = bus.id_imm;
            n.pc      = bus.id_pc;
            n.alu     = bus.id_alu_sel;
            n.src_imm = bus.id_alu_src_imm;
            n.src_pc  = bus.id_alu_src_pc;
            n.rw      = bus.id_reg_write;
            n.mr      = bus.id_mem_read;
            n.mw      = bus.id_mem_write;
            ex_slot   = n;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        #3;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("ex_valid", 32'(bus.ex_valid), 32'(e.valid));
            chk("stall", 32'(bus.stall), 32'(e.stall));
            chk("ex_alu_sel", 32'(bus.ex_alu_sel), 32'(e.alu));
            chk("ex_reg_write", 32'(bus.ex_reg_write), 32'(e.rw));
            chk("ex_mem_read", 32'(bus.ex_mem_read), 32'(e.mr));
            chk("ex_mem_write", 32'(bus.ex_mem_write), 32'(e.mw));
            if (e.valid) begin
                chk("ex_rd", 32'(bus.ex_rd), 32'(e.rd));
                chk("ex_pc", bus.ex_pc, e.pc);
                chk("ex_src1", bus.ex_src1, e.src1);
                chk("ex_src2", bus.ex_src2, e.src2);
                chk("ex_store_data", bus.ex_store_data, e.sd);
            end
        end
    end

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] alu,
                          input logic simm, input logic spc, input logic rw, input logic mr,
                          input logic mw);
        bus.id_valid = v;        bus.id_rs1 = rs1;          bus.id_rs2 = rs2;
        bus.id_rd = rd;          bus.id_rs1_data = d1;      bus.id_rs2_data = d2;
        bus.id_imm = imm;        bus.id_pc = pc;            bus.id_alu_sel = alu;
        bus.id_alu_src_imm = simm; bus.id_alu_src_pc = spc; bus.id_reg_write = rw;
        bus.id_mem_read = mr;    bus.id_mem_write = mw;
    endtask

    task automatic set_fwd(input logic erw, input logic [4:0] erd, input logic [31:0] eres,
                           input logic mrw, input logic [4:0] mrd, input logic [31:0] mres);
        bus.exmem_reg_write = erw; bus.exmem_rd = erd; bus.exmem_result = eres;
        bus.memwb_reg_write = mrw; bus.memwb_rd = mrd; bus.memwb_result = mres;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        ex_slot  = bubble();
        bus.flush = 1'b0;
        idle();
        set_fwd(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bus.ex_valid), 0);
        chk("rst_alu_sel", 32'(bus.ex_alu_sel), 32'(ALU_NOP));
        chk("rst_reg_write", 32'(bus.ex_reg_write), 0);
        chk("rst_rd", 32'(bus.ex_rd), 0);
        chk("rst_pc", bus.ex_pc, 0);
        chk("rst_src1", bus.ex_src1, 0);
        chk("rst_src2", bus.ex_src2, 0);
        chk("rst_store", bus.ex_store_data, 0);
        chk("rst_stall", 32'(bus.stall), 0);
        rst = 1'b0;

        // addi x1,x0,5 then add x2,x1,x1 with EX/MEM forwarding
        @(negedge clk); set_id(1, 0, 0, 1, 0, 0, 5, 32'h100, 4'h0, 1, 0, 1, 0, 0); issue();
        @(negedge clk); set_id(1, 1, 1, 2, 32'hDEAD, 32'hDEAD, 0, 32'h104, 4'h0, 0, 0, 1, 0, 0); issue();
        chk("b2b_addi_src2", bus.ex_src2, 5);
        @(negedge clk); idle(); set_fwd(1, 1, 5, 0, 0, 0); issue();
        chk("b2b_src1", bus.ex_src1, 5);
        chk("b2b_src2", bus.ex_src2, 5);

        // EX/MEM beats MEM/WB
        @(negedge clk); set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 3, 0, 9, 32'h1111, 0, 0, 32'h200, 4'h1, 0, 0, 1, 0, 0); issue();
        @(negedge clk); idle(); set_fwd(1, 3, 32'hAAAA, 1, 3, 32'hBBBB); issue();
        chk("double_hazard", bus.ex_src1, 32'hAAAA);

        // load-use: one bubble then MEM/WB forward
        @(negedge clk); set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 0, 0, 4, 0, 0, 32'h10, 32'h300, 4'h0, 1, 0, 1, 1, 0); issue();
        @(negedge clk); set_id(1, 1, 4, 5, 32'h5, 32'hBAD, 0, 32'h304, 4'h0, 0, 0, 1, 0, 0); issue();
        chk("lu_stall", 32'(bus.stall), 1);
        @(negedge clk); issue();
        chk("lu_bubble_valid", 32'(bus.ex_valid), 0);
        chk("lu_bubble_alu", 32'(bus.ex_alu_sel), 32'(ALU_NOP));
        chk("lu_stall_clear", 32'(bus.stall), 0);
        @(negedge clk); idle(); set_fwd(0, 0, 0, 1, 4, 32'h77); issue();
        chk("lu_dep_valid", 32'(bus.ex_valid), 1);
        chk("lu_dep_src2", bus.ex_src2, 32'h77);

        // x0 never forwarded
        @(negedge clk); set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 0, 2, 6, 0, 0, 0, 32'h400, 4'h2, 0, 0, 1, 0, 0); issue();
        @(negedge clk); idle(); set_fwd(1, 0, 32'hFFFFFFFF, 0, 0, 0); issue();
        chk("x0_src1", bus.ex_src1, 0);

        // flush overrides load-use; then WB bypass on capture
        @(negedge clk); set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 0, 0, 5, 0, 0, 32'h20, 32'h500, 4'h0, 1, 0, 1, 1, 0); issue();
        @(negedge clk); set_id(1, 5, 0, 6, 0, 0, 0, 32'h504, 4'h0, 0, 0, 1, 0, 0);
        bus.flush = 1'b1; issue();
        chk("flush_stall", 32'(bus.stall), 0);
        @(negedge clk); bus.flush = 1'b0; idle(); issue();
        chk("flush_bubble", 32'(bus.ex_valid), 0);
        @(negedge clk); set_id(1, 7, 0, 8, 32'h1, 0, 0, 32'h600, 4'h3, 0, 0, 1, 0, 0);
        set_fwd(0, 0, 0, 1, 7, 32'h1234); issue();
        @(negedge clk); idle(); set_fwd(0, 0, 0, 0, 0, 0); issue();
        chk("wb_bypass", bus.ex_src1, 32'h1234);

        // async reset between edges
        @(negedge clk); set_id(1, 1, 2, 3, 0, 0, 0, 32'h700, 4'h4, 0, 0, 1, 0, 0); issue();
        @(negedge clk); idle(); #1;
        chk("pre_rst_valid", 32'(bus.ex_valid), 1);
        #1 rst = 1'b1; #1;
        chk("async_rst_valid", 32'(bus.ex_valid), 0);
        chk("async_rst_rw", 32'(bus.ex_reg_write), 0);
        @(negedge clk); rst = 1'b0; ex_slot = bubble();

        // reset during a load-use stall
        @(negedge clk); set_id(1, 0, 0, 4, 0, 0, 32'h8, 32'h800, 4'h0, 1, 0, 1, 1, 0); issue();
        @(negedge clk); set_id(1, 4, 0, 9, 32'h3, 0, 0, 32'h804, 4'h5, 0, 0, 1, 0, 0); #1;
        chk("mid_stall", 32'(bus.stall), 1);
        #1 rst = 1'b1; #1;
        chk("rst_clears_stall", 32'(bus.stall), 0);
        @(negedge clk); rst = 1'b0; ex_slot = bubble(); issue();
        @(negedge clk); idle(); issue();
        chk("post_rst_load", 32'(bus.ex_valid), 1);
        chk("post_rst_src1", bus.ex_src1, 32'h3);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            set_id(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom,
                   4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
            set_fwd(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom), 5'($urandom_range(0, 7)), $urandom);
            bus.flush = ($urandom_range(0, 7) == 0);
            issue();
        end

        @(negedge clk); bus.flush = 1'b0; idle();
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
